// File: rtl/baud_rate_controller_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_cfg_pkg
// Brief   : Rate codes, controller states and divider tables for UART baud timing
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_cfg_pkg;

  typedef enum logic [1:0] {
    B4800   = 2'b00,
    B9600   = 2'b01,
    B115200 = 2'b10,
    BDEBUG  = 2'b11
  } baud_sel_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    RELOAD = 2'd2
  } ctrl_state_e;

  localparam int unsigned c_baud_rate [4] = '{4800, 9600, 115200, 1};

  // Reference divisors for the 100 MHz / 16x build
  localparam int unsigned OS_DIV [4] = '{1302, 651, 54, 6_250_000};

  function automatic int unsigned calc_os_div(input int unsigned clk_freq,
                                              input int unsigned oversample,
                                              input int unsigned idx);
    return clk_freq / (c_baud_rate[idx] * oversample);
  endfunction

endpackage

`default_nettype wire

// File: rtl/baud_rate_controller_baud_tick_gen.sv
//------------------------------------------------------------------------------
// Module  : baud_tick_gen
// Brief   : Reloadable oversample divider producing os_tick and baud_tick enables
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module baud_tick_gen #(
  parameter int unsigned CNT_W      = 23,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] div_m1,
  output logic             os_tick,
  output logic             baud_tick
);

  localparam int unsigned c_idx_w = $clog2(OVERSAMPLE);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(OVERSAMPLE - 1);

  logic [CNT_W-1:0]   r_os_cnt;
  logic [c_idx_w-1:0] r_os_idx;
  logic               r_os_tick;
  logic               r_baud_tick;
  logic               w_wrap;

  assign w_wrap = (r_os_cnt == div_m1);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_os_cnt    <= '0;
      r_os_idx    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else if (!enable || load) begin
      r_os_cnt    <= '0;
      r_os_idx    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else begin
      r_os_tick   <= w_wrap;
      r_baud_tick <= w_wrap && (r_os_idx == c_idx_last);
      if (w_wrap) begin
        r_os_cnt <= '0;
        r_os_idx <= r_os_idx + c_idx_w'(1);
      end else begin
        r_os_cnt <= r_os_cnt + CNT_W'(1);
      end
    end
  end

  // A tick registered just before a reload is swallowed so the reload cycle stays quiet
  assign os_tick   = r_os_tick && !load;
  assign baud_tick = r_baud_tick && !load;

endmodule

`default_nettype wire

// File: rtl/baud_rate_controller.sv
//------------------------------------------------------------------------------
// Module  : baud_rate_controller
// Brief   : UART baud timing with req/ack rate switching applied only while idle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module baud_rate_controller
  import uart_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned CNT_W       = 23,
  parameter logic [1:0]  DEFAULT_SEL = 2'b01
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] cfg_sel,
  input  logic       cfg_req,
  output logic       cfg_ack,
  input  logic       uart_busy,
  output logic       os_tick,
  output logic       baud_tick,
  output logic [1:0] active_sel,
  output logic       switching
);

  localparam int unsigned c_os_div [4] = '{
    calc_os_div(CLK_FREQ, OVERSAMPLE, 0),
    calc_os_div(CLK_FREQ, OVERSAMPLE, 1),
    calc_os_div(CLK_FREQ, OVERSAMPLE, 2),
    calc_os_div(CLK_FREQ, OVERSAMPLE, 3)
  };

  ctrl_state_e r_state, w_state_nxt;
  baud_sel_e   r_active_sel, w_active_nxt;
  baud_sel_e   r_pend_sel, w_pend_nxt;
  baud_sel_e   w_req_sel;
  logic        r_ack, w_ack_nxt;
  logic        w_reload;
  int unsigned w_div_full;
  logic [CNT_W-1:0] w_div_m1;

  assign w_req_sel = baud_sel_e'(cfg_sel);
  assign w_reload  = (r_state == RELOAD);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_active_sel <= baud_sel_e'(DEFAULT_SEL);
      r_pend_sel   <= baud_sel_e'(DEFAULT_SEL);
      r_ack        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_active_sel <= w_active_nxt;
      r_pend_sel   <= w_pend_nxt;
      r_ack        <= w_ack_nxt;
    end
  end

  // The ack for a real switch is registered on entry to RELOAD, so it is visible during RELOAD
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active_sel;
    w_pend_nxt   = r_pend_sel;
    w_ack_nxt    = 1'b0;
    case (r_state)
      RUN: begin
        if (cfg_req) begin
          if (w_req_sel == r_active_sel) begin
            w_ack_nxt = 1'b1;
          end else begin
            w_pend_nxt  = w_req_sel;
            w_state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (cfg_req) begin
          w_pend_nxt = w_req_sel;
        end
        if (!uart_busy) begin
          w_state_nxt = RELOAD;
          w_ack_nxt   = 1'b1;
        end
      end
      RELOAD: begin
        w_active_nxt = r_pend_sel;
        if (cfg_req && (w_req_sel != r_pend_sel)) begin
          w_pend_nxt  = w_req_sel;
          w_state_nxt = PEND;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_div_full = c_os_div[r_active_sel];
  assign w_div_m1   = CNT_W'(w_div_full - 1);

  baud_tick_gen #(
    .CNT_W      (CNT_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick_gen (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .load      (w_reload),
    .div_m1    (w_div_m1),
    .os_tick   (os_tick),
    .baud_tick (baud_tick)
  );

  assign cfg_ack    = r_ack;
  assign active_sel = r_active_sel;
  assign switching  = (r_state != RUN);

endmodule

`default_nettype wire

// File: tb/tb_baud_rate_controller.sv
//------------------------------------------------------------------------------
// Module  : tb_baud_rate_controller
// Brief   : Self-checking bench for baud_rate_controller
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_baud_rate_controller;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] cfg_sel;
  logic       cfg_req;
  logic       cfg_ack;
  logic       uart_busy;
  logic       os_tick;
  logic       baud_tick;
  logic [1:0] active_sel;
  logic       switching;

  baud_rate_controller dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (enable),
    .cfg_sel    (cfg_sel),
    .cfg_req    (cfg_req),
    .cfg_ack    (cfg_ack),
    .uart_busy  (uart_busy),
    .os_tick    (os_tick),
    .baud_tick  (baud_tick),
    .active_sel (active_sel),
    .switching  (switching)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_q[$];
  int exp_ack;

  typedef struct {
    logic [1:0] sel;
    int         active;
    int         lat;
    int         div;
  } vec_t;
  vec_t vec [4];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every ack must match the next expected ack cycle
  always @(negedge clk_in) begin
    if (cfg_ack === 1'b1) begin
      if (ack_q.size() == 0) begin
        check("unexpected_ack", cyc, -1);
      end else begin
        exp_ack = ack_q.pop_front();
        check("ack_cycle", cyc, exp_ack);
      end
    end
  end

  task automatic wait_ev(input int which, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if ((which == 0 && os_tick === 1'b1) || (which == 1 && baud_tick === 1'b1)) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int t, t0, t1, t2, t_en, c, bad, exp_t;

  initial begin
    vec[0] = '{2'b10, 2, 2, 54};
    vec[1] = '{2'b10, 2, 1, 54};
    vec[2] = '{2'b00, 0, 2, 1302};
    vec[3] = '{2'b01, 1, 2, 651};

    reset = 1'b1; enable = 1'b0; cfg_req = 1'b0; cfg_sel = 2'b00; uart_busy = 1'b0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check("rst_active_sel", active_sel, 1);
    check("rst_switching", switching, 0);
    check("rst_os_tick", os_tick, 0);
    check("rst_cfg_ack", cfg_ack, 0);

    // Default rate timing from enable rise
    enable = 1'b1; t_en = cyc;
    wait_ev(0, 700, t);
    check("first_os_tick", t - t_en, 651);
    wait_ev(0, 700, t2);
    check("os_period_9600", t2 - t, 651);
    wait_ev(1, 11000, t);
    check("first_baud_tick", t - t_en, 10416);
    check("baud_with_os", os_tick, 1);

    for (int i = 0; i < 4; i++) begin
      wait_ev(0, 1400, t0);
      cfg_sel = vec[i].sel; cfg_req = 1'b1; c = cyc;
      ack_q.push_back(c + vec[i].lat);
      @(negedge clk_in);
      cfg_req = 1'b0;
      wait_ev(0, 1400, t1);
      exp_t = (vec[i].lat == 1) ? t0 + vec[i].div : c + vec[i].lat + 1 + vec[i].div;
      check($sformatf("vec%0d_first_tick", i), t1, exp_t);
      check($sformatf("vec%0d_active_sel", i), active_sel, vec[i].active);
      check($sformatf("vec%0d_switching", i), switching, 0);
      wait_ev(0, 1400, t2);
      check($sformatf("vec%0d_period", i), t2 - t1, vec[i].div);
    end

    // Busy blocks the switch
    uart_busy = 1'b1; cfg_sel = 2'b00; cfg_req = 1'b1;
    @(negedge clk_in);
    cfg_req = 1'b0;
    bad = 0;
    for (int k = 0; k < 5000; k++) begin
      if (switching !== 1'b1 || active_sel !== 2'd1 || cfg_ack !== 1'b0) bad++;
      @(negedge clk_in);
    end
    check("busy_hold_violations", bad, 0);
    uart_busy = 1'b0; c = cyc;
    ack_q.push_back(c + 1);
    wait_ev(0, 1500, t1);
    check("busy_release_first_tick", t1, c + 2 + 1302);
    check("busy_release_active", active_sel, 0);
    wait_ev(0, 1500, t2);
    check("busy_release_period", t2 - t1, 1302);

    // Overwrite while pending: one ack, last rate wins
    uart_busy = 1'b1; cfg_sel = 2'b10; cfg_req = 1'b1;
    @(negedge clk_in);
    cfg_req = 1'b0;
    @(negedge clk_in);
    cfg_sel = 2'b01; cfg_req = 1'b1;
    @(negedge clk_in);
    cfg_req = 1'b0;
    @(negedge clk_in);
    uart_busy = 1'b0; c = cyc;
    ack_q.push_back(c + 1);
    wait_ev(0, 1500, t1);
    check("overwrite_first_tick", t1, c + 2 + 651);
    check("overwrite_active", active_sel, 1);

    // New request during RELOAD re-enters PEND
    @(negedge clk_in);
    cfg_sel = 2'b10; cfg_req = 1'b1; c = cyc;
    ack_q.push_back(c + 2);
    ack_q.push_back(c + 4);
    @(negedge clk_in);
    cfg_req = 1'b0;
    @(negedge clk_in);
    cfg_sel = 2'b00; cfg_req = 1'b1;
    @(negedge clk_in);
    cfg_req = 1'b0;
    wait_ev(0, 1500, t1);
    check("reload_rereq_first_tick", t1, c + 5 + 1302);
    check("reload_rereq_active", active_sel, 0);

    // Reset while pending abandons the request
    uart_busy = 1'b1; cfg_sel = 2'b10; cfg_req = 1'b1;
    @(negedge clk_in);
    cfg_req = 1'b0;
    @(negedge clk_in);
    check("pend_switching", switching, 1);
    reset = 1'b1;
    #1;
    check("async_rst_active", active_sel, 1);
    check("async_rst_switching", switching, 0);
    enable = 1'b0;
    @(negedge clk_in);
    reset = 1'b0; uart_busy = 1'b0;
    bad = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_in);
      if (os_tick !== 1'b0 || baud_tick !== 1'b0 || cfg_ack !== 1'b0) bad++;
    end
    check("disabled_tick_count", bad, 0);
    check("abandoned_ack_q", ack_q.size(), 0);
    enable = 1'b1; t_en = cyc;
    wait_ev(0, 700, t);
    check("reenable_first_tick", t - t_en, 651);

    repeat (3) @(negedge clk_in);
    check("ack_q_drained", ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
